vend_controller: RTL and testbench

- Sequencing controller for the nickel/dime vending datapath.
- Accumulates coin credit and requests a dispense from the dispenser with a req/ack handshake.
- Returns change or refunds one nickel per cycle; enforces a cancel and inactivity timeout.
- Sits between the coin-sense inputs (x1/x0 coin code) and the dispenser/change hopper.

---
 rtl/vend_controller.sv | 171 +++++++++++++++++
 tb/tb_vend_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// Nickel/dime vending sequencer: accumulates credit, runs the dispenser req/ack
// handshake, and pays out change or refunds one nickel per cycle.
module vend_controller #(
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 6,
    parameter int TIMEOUT    = 16,
    parameter int CW         = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          x1,
    input  logic          x0,
    input  logic          cancel,
    input  logic          vend_ack,
    output logic          vend_req,
    output logic          chg_nickel,
    output logic          coin_rej,
    output logic [CW-1:0] credit,
    output logic          busy,
    output logic [2:0]    state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_VEND    = 3'd2;
    localparam logic [2:0] S_CHANGE  = 3'd3;
    localparam logic [2:0] S_REFUND  = 3'd4;

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_ONE   = TW'(1);
    localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW:0]   PRICE_W = (CW+1)'(PRICE);
    localparam logic [CW:0]   MAX_W   = (CW+1)'(MAX_CREDIT);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          vend_req_q, vend_req_d;
    logic          chg_nickel_q, chg_nickel_d;
    logic          coin_rej_q, coin_rej_d;
    logic          busy_q, busy_d;

    logic [CW:0]   coin_val_s;
    logic [CW:0]   sum_s;
    logic          coin_s;

    // Coin decode; the invalid code 10 is treated as no coin at all.
    always_comb begin
        case ({x1, x0})
            2'b01:   coin_val_s = (CW+1)'(1);
            2'b11:   coin_val_s = (CW+1)'(2);
            default: coin_val_s = '0;
        endcase
        coin_s = (coin_val_s != '0);
        sum_s  = {1'b0, credit_q} + coin_val_s;
    end

    // Next-state, credit and pulse computation.
    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        timer_d      = timer_q;
        coin_rej_d   = 1'b0;
        chg_nickel_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (coin_s) begin
                    credit_d = sum_s[CW-1:0];
                    if (sum_s >= PRICE_W) begin
                        state_d = S_VEND;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end else begin
                    credit_d = '0;
                end
            end
            S_COLLECT: begin
                // cancel wins over a simultaneous coin, which is bounced
                if (cancel) begin
                    state_d    = S_REFUND;
                    coin_rej_d = coin_s;
                    timer_d    = '0;
                end else if (coin_s) begin
                    if (sum_s > MAX_W) begin
                        coin_rej_d = 1'b1;
                    end else begin
                        credit_d = sum_s[CW-1:0];
                        timer_d  = '0;
                        if (sum_s >= PRICE_W) begin
                            state_d = S_VEND;
                        end else begin
                            state_d = S_COLLECT;
                        end
                    end
                end else if (timer_q == TMAX) begin
                    state_d = S_REFUND;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + T_ONE;
                end
            end
            S_VEND: begin
                coin_rej_d = coin_s;
                if (vend_ack) begin
                    credit_d = credit_q - PRICE_C;
                    if (credit_q > PRICE_C) begin
                        state_d = S_CHANGE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_VEND;
                end
            end
            S_CHANGE, S_REFUND: begin
                coin_rej_d = coin_s;
                if (credit_q != '0) begin
                    chg_nickel_d = 1'b1;
                    credit_d     = credit_q - ONE_C;
                end else begin
                    credit_d = '0;
                end
                if (credit_q <= ONE_C) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
                timer_d  = '0;
            end
        endcase
        vend_req_d = (state_d == S_VEND);
        busy_d     = (state_d == S_VEND) || (state_d == S_CHANGE) || (state_d == S_REFUND);
    end

    // State and registered outputs; reset discards credit without paying change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            credit_q     <= '0;
            timer_q      <= '0;
            vend_req_q   <= 1'b0;
            chg_nickel_q <= 1'b0;
            coin_rej_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            timer_q      <= timer_d;
            vend_req_q   <= vend_req_d;
            chg_nickel_q <= chg_nickel_d;
            coin_rej_q   <= coin_rej_d;
            busy_q       <= busy_d;
        end
    end

    assign state      = state_q;
    assign credit     = credit_q;
    assign vend_req   = vend_req_q;
    assign chg_nickel = chg_nickel_q;
    assign coin_rej   = coin_rej_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed scenarios followed by random coin/cancel/ack
// traffic, all outputs compared each cycle against a behavioural model.
module tb_vend_controller;

    localparam int PRICE      = 3;
    localparam int MAX_CREDIT = 6;
    localparam int TIMEOUT    = 16;
    localparam int CW         = 3;

    localparam int M_IDLE = 0, M_COLLECT = 1, M_VEND = 2, M_CHANGE = 3, M_REFUND = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          x1 = 1'b0, x0 = 1'b0, cancel = 1'b0, vend_ack = 1'b0;
    logic          vend_req, chg_nickel, coin_rej, busy;
    logic [CW-1:0] credit;
    logic [2:0]    state;

    int n_assert = 0;
    int n_fail   = 0;
    int chg_seen = 0;

    int m_mode, m_credit, m_idle, m_chg, m_rej;

    vend_controller #(
        .PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT), .TIMEOUT(TIMEOUT), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .x1(x1), .x0(x0), .cancel(cancel), .vend_ack(vend_ack),
        .vend_req(vend_req), .chg_nickel(chg_nickel), .coin_rej(coin_rej),
        .credit(credit), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        check({where, " state"},      {5'b0, state},      8'(m_mode));
        check({where, " credit"},     {5'b0, credit},     8'(m_credit));
        check({where, " vend_req"},   {7'b0, vend_req},   8'(m_mode == M_VEND));
        check({where, " chg_nickel"}, {7'b0, chg_nickel}, 8'(m_chg));
        check({where, " coin_rej"},   {7'b0, coin_rej},   8'(m_rej));
        check({where, " busy"},       {7'b0, busy},       8'(m_mode >= M_VEND));
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_credit = 0; m_idle = 0; m_chg = 0; m_rej = 0;
    endtask

    // Behavioural rules: what one clock edge does to credit and the machine's phase.
    task automatic model_step(input int coin, input bit can, input bit ack);
        m_chg = 0;
        m_rej = 0;
        if (m_mode == M_IDLE) begin
            if (coin > 0) begin
                m_credit = coin;
                m_idle   = 0;
                m_mode   = (coin >= PRICE) ? M_VEND : M_COLLECT;
            end
        end else if (m_mode == M_COLLECT) begin
            if (can) begin
                m_rej  = (coin > 0);
                m_mode = M_REFUND;
            end else if (coin > 0) begin
                if (m_credit + coin > MAX_CREDIT) m_rej = 1;
                else begin
                    m_credit += coin;
                    m_idle = 0;
                    if (m_credit >= PRICE) m_mode = M_VEND;
                end
            end else begin
                m_idle++;
                if (m_idle == TIMEOUT) m_mode = M_REFUND;
            end
        end else if (m_mode == M_VEND) begin
            m_rej = (coin > 0);
            if (ack) begin
                m_credit -= PRICE;
                m_mode = (m_credit > 0) ? M_CHANGE : M_IDLE;
            end
        end else begin
            m_rej = (coin > 0);
            if (m_credit > 0) begin
                m_chg = 1;
                m_credit--;
            end
            if (m_credit == 0) m_mode = M_IDLE;
        end
    endtask

    task automatic cycle(input bit a1, input bit a0, input bit can, input bit ack);
        int coin;
        coin = (!a1 && a0) ? 1 : ((a1 && a0) ? 2 : 0);
        x1 = a1; x0 = a0; cancel = can; vend_ack = ack;
        @(posedge clk);
        model_step(coin, can, ack);
        #1;
        check_all("cyc");
        if (chg_nickel === 1'b1) chg_seen++;
    endtask

    // Asserts reset between edges, checks it took effect without a clock, then releases.
    task automatic apply_reset();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_held");
        #2;
        rst = 1'b1;
    endtask

    initial begin
        bit [3:0] r;
        bit       a1, a0;
        model_reset();
        #1;
        apply_reset();

        // dime, nickel, dime
        cycle(1, 1, 0, 0); check("t1 credit2", {5'b0, credit}, 8'd2);
        cycle(0, 1, 0, 0); check("t1 credit3", {5'b0, credit}, 8'd3);
        check("t1 req", {7'b0, vend_req}, 8'd1);
        cycle(1, 1, 0, 0); check("t1 rej", {7'b0, coin_rej}, 8'd1);
        chg_seen = 0;
        cycle(0, 0, 0, 1); check("t1 idle", {5'b0, state}, 8'd0);
        cycle(0, 0, 0, 0); check("t1 no chg", 8'(chg_seen), 8'd0);

        // four nickels, ack two cycles later
        cycle(0, 1, 0, 0); cycle(0, 1, 0, 0); cycle(0, 1, 0, 0);
        check("t2 vend", {5'b0, state}, 8'd2);
        cycle(0, 1, 0, 0); check("t2 rej", {7'b0, coin_rej}, 8'd1);
        check("t2 credit", {5'b0, credit}, 8'd3);
        cycle(0, 0, 0, 0); cycle(0, 0, 0, 1);
        check("t2 idle", {5'b0, state}, 8'd0);

        // two dimes then change
        cycle(1, 1, 0, 0); cycle(1, 1, 0, 0);
        check("t3 credit4", {5'b0, credit}, 8'd4);
        chg_seen = 0;
        cycle(0, 0, 0, 1); check("t3 change", {5'b0, state}, 8'd3);
        cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
        check("t3 chg count", 8'(chg_seen), 8'd1);

        // inactivity timeout
        cycle(0, 1, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) cycle(0, 0, 0, 0);
        check("t4 not yet", {5'b0, state}, 8'd1);
        cycle(0, 0, 0, 0); check("t4 refund", {5'b0, state}, 8'd4);
        chg_seen = 0;
        cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
        check("t4 chg count", 8'(chg_seen), 8'd1);

        // coin together with cancel
        cycle(0, 1, 0, 0);
        cycle(1, 1, 1, 0); check("t5 rej", {7'b0, coin_rej}, 8'd1);
        check("t5 refund", {5'b0, state}, 8'd4);
        chg_seen = 0;
        cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
        check("t5 chg count", 8'(chg_seen), 8'd1);

        // reset while vending
        cycle(1, 1, 0, 0); cycle(0, 1, 0, 0);
        check("t6 vend", {5'b0, state}, 8'd2);
        apply_reset();
        cycle(1, 1, 0, 0); check("t6 after", {5'b0, credit}, 8'd2);

        // random traffic, coin-heavy then idle-heavy to reach timeouts
        for (int i = 0; i < 1200; i++) begin
            r = 4'($urandom_range(0, 15));
            if (i < 700) begin
                a1 = (r >= 4'd10); a0 = (r >= 4'd6 && r != 4'd10);
            end else begin
                a1 = ($urandom_range(0, 39) == 0); a0 = ($urandom_range(0, 29) == 0);
            end
            cycle(a1, a0, ($urandom_range(0, 11) == 0), ($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 249) == 0) apply_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
